output_buffer: RTL and testbench
================================

# output_buffer

Output-side storage stage directly downstream of the accumulator. It captures the single-word writes the accumulator issues (data, 4-bit address, enable) into a DEPTH-entry register file and tracks which entries hold results. A host-requested drain streams a contiguous, wrapping range of entries out over a valid/ready interface. Each drained entry is released after it is sent.

## Interface
- DATA_W, 32, width of one stored result word
- DEPTH, 16, number of entries (power of two)
- ADDR_W, 4, entry address width, log2(DEPTH)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe, driven by accumulator output_buffer_enable
- wr_addr  in  ADDR_W  write entry, driven by accumulator output_buffer_addr
- wr_data  in  DATA_W  write word, driven by accumulator output_data
- drain_start  in  1  single-cycle drain request
- drain_base  in  ADDR_W  first entry to drain
- drain_count  in  ADDR_W+1  entries to drain, 1..DEPTH
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts the current word
- out_data  out  DATA_W  drained word
- out_addr  out  ADDR_W  entry the word came from
- out_last  out  1  final word of the current drain
- busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse after the last handshake
- rd_unwritten  out  1  sticky: a drained entry had no valid result
- occupancy  out  ADDR_W+1  count of valid entries (see Configuration)

## Operation
- Storage: DEPTH x DATA_W words plus one valid bit per entry.
- Write: when wr_en=1, the entry is written and its valid bit is set. Writes are accepted every cycle, including during a drain, and are never back-pressured.
- FSM states:
  - IDLE: waits for a request. drain_start with drain_count≠0 latches the base and count (count >DEPTH is clamped to DEPTH), clears rd_unwritten, and moves to LOAD. drain_count=0 is ignored.
  - LOAD: loads entry ptr into the output register, sets out_valid, and moves to SEND.
  - SEND: on out_valid&&out_ready, clears the sent entry's valid bit and decrements the remaining count. If entries remain, ptr advances (ptr+1 mod DEPTH, wrapping 15→0) and the next entry is loaded in the same cycle, so throughput is 1 word/cycle. Otherwise out_valid drops and the FSM moves to DONE.
  - DONE: pulses drain_done for one cycle, then returns to IDLE.
- out_last=1 while the word being presented is the final one of the drain.
- Loading an entry whose valid bit is 0 outputs the stored (stale or reset-zero) data and sets rd_unwritten.
- drain_start while busy=1 is ignored. It is not queued.
- Simultaneous events:
  - A write to the entry being loaded in the same cycle bypasses storage: the new wr_data is loaded into the output register and treated as valid.
  - A write coinciding with the clear of the same entry leaves the valid bit set (set wins). The stored word is the new data.
- busy=1 in LOAD, SEND and DONE.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_addr=0, out_last=0
  - busy=0, drain_done=0, rd_unwritten=0, occupancy=0
  - all valid bits 0, all storage words 0, FSM=IDLE
- Reset mid-drain aborts the drain immediately (asynchronous). No drain_done is issued.
- Write latency: a word written in cycle N is readable by a load in cycle N+1. Same-cycle reads are served by the bypass.
- drain_start sampled in cycle N: busy=1 from N+1, out_valid=1 from N+2 with entry drain_base.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_addr and out_last hold steady.
- Drain of K words with out_ready held at 1: handshakes in cycles N+2..N+K+1, drain_done in N+K+2, busy=0 from N+K+3.

## Configuration
- OUTPUT_BUFFER_OCC_EN defined: a counter tracks the number of valid bits set.
  - +1 on a write to an invalid entry.
  - −1 on a handshake clear of an entry that is not rewritten in the same cycle.
  - Net 0 when a set and a clear hit different entries in the same cycle.
  - Range 0..DEPTH.
- Undefined: no counter logic is built and occupancy is tied to 0. All other behaviour is identical.

## Test plan
- After reset, write entries 0..3 with 10, 20, 30, 40, then drain base=0, count=4 with out_ready=1. Expected: words 10, 20, 30, 40 (addr 0..3) in 4 consecutive cycles, out_last on addr 3, drain_done one cycle later, rd_unwritten=0; occupancy 4→0 with the macro.
- Wrap: write entries 14, 15, 0 with 0xA, 0xB, 0xC, then drain base=14, count=3. Expected: addr 14, 15, 0 in order, data A, B, C.
- Back-pressure: out_ready=0 for 3 cycles mid-drain. Expected: out_data/out_addr stable, no entry skipped or duplicated, valid bits cleared only on handshake.
- Unwritten/bypass: drain base=5, count=2 with entry 6 never written but wr_en to entry 6 with 0x55 in its load cycle. Expected: entry 5 sets rd_unwritten, entry 6 returns 0x55.
- Edge requests: drain_count=0 → no activity. drain_count=20 → exactly 16 words. drain_start while busy → ignored.
- rst asserted during SEND. Expected: out_valid and busy drop to 0 without a clock, all valid bits clear, occupancy=0, and a following drain returns data 0 with rd_unwritten=1.

Source files
------------

// File: rtl/output_buffer.sv
// Output buffer: DEPTH-entry result store with per-entry valid bits and a wrapping valid/ready drain.
// Optional occupancy counter built only when OUTPUT_BUFFER_OCC_EN is defined (otherwise occupancy = 0).
//
// state  | meaning
// IDLE   | waiting for drain_start with a non-zero count
// LOAD   | first drained entry goes into the output register
// SEND   | word presented; each handshake releases it and loads the next
// DONE   | one-cycle drain_done pulse, then back to IDLE
module output_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              drain_done,
    output logic              rd_unwritten,
    output logic [ADDR_W:0]   occupancy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    vld, vld_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt, load_ptr;
    logic [ADDR_W:0]     remaining, remaining_nxt;
    logic                hs, load, load_last, start_ok, bypass, load_vld;
    logic [DATA_W-1:0]   load_data;

    assign hs         = out_valid && out_ready;
    assign busy       = (state != S_IDLE);
    assign drain_done = (state == S_DONE);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        load          = 1'b0;
        load_ptr      = ptr;
        load_last     = 1'b0;
        start_ok      = 1'b0;
        case (state)
            S_IDLE: begin
                if (drain_start && drain_count != '0) begin
                    start_ok      = 1'b1;
                    ptr_nxt       = drain_base;
                    remaining_nxt = (drain_count > DEPTH_CNT) ? DEPTH_CNT : drain_count;
                    state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                load      = 1'b1;
                load_last = (remaining == (ADDR_W+1)'(1));
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (hs) begin
                    remaining_nxt = remaining - 1'b1;
                    if (remaining != (ADDR_W+1)'(1)) begin
                        // next entry loads in the handshake cycle for 1 word/cycle
                        ptr_nxt   = ptr + 1'b1;
                        load_ptr  = ptr + 1'b1;
                        load      = 1'b1;
                        load_last = (remaining == (ADDR_W+1)'(2));
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // a write landing on the entry being loaded is forwarded and counts as valid
    assign bypass    = wr_en && (wr_addr == load_ptr);
    assign load_data = bypass ? wr_data : mem[load_ptr];
    assign load_vld  = bypass || vld[load_ptr];

    always_comb begin
        vld_nxt = vld;
        if (hs)
            vld_nxt[out_addr] = 1'b0;
        if (wr_en)
            vld_nxt[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            vld       <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            vld       <= vld_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_addr     <= '0;
            out_last     <= 1'b0;
            rd_unwritten <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_addr  <= load_ptr;
                out_last  <= load_last;
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (start_ok)
                rd_unwritten <= 1'b0;
            else if (load && !load_vld)
                rd_unwritten <= 1'b1;
        end
    end

`ifdef OUTPUT_BUFFER_OCC_EN
    logic occ_inc, occ_dec;
    assign occ_inc = wr_en && !vld[wr_addr];
    // a clear that is overridden by a same-entry write leaves the bit set
    assign occ_dec = hs && vld[out_addr] && !(wr_en && wr_addr == out_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            occupancy <= '0;
        else if (occ_inc && !occ_dec)
            occupancy <= occupancy + 1'b1;
        else if (occ_dec && !occ_inc)
            occupancy <= occupancy - 1'b1;
    end
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: fill/drain, wrap, back-pressure, bypass, edge requests, async reset.
module tb_output_buffer;
`ifdef OUTPUT_BUFFER_OCC_EN
    localparam bit OCC = 1'b1;
`else
    localparam bit OCC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        drain_start = 1'b0;
    logic [3:0]  drain_base = '0;
    logic [4:0]  drain_count = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_addr;
    logic        out_last;
    logic        busy;
    logic        drain_done;
    logic        rd_unwritten;
    logic [4:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] got_data [32];
    logic [3:0]  got_addr [32];
    logic        got_last [32];
    int nwords, done_cyc;

    output_buffer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .drain_start(drain_start), .drain_base(drain_base), .drain_count(drain_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .drain_done(drain_done),
        .rd_unwritten(rd_unwritten), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // c counts cycles after the start request was sampled (c=1 is N+1)
    task automatic run_drain(input logic [3:0] base, input logic [4:0] cnt,
                             input int stall_at, input int stall_len,
                             input int wr_cyc, input logic [3:0] wa, input logic [31:0] wd,
                             input int rs_cyc);
        int stalled;
        stalled = 0; nwords = 0; done_cyc = -1;
        drain_base = base; drain_count = cnt; drain_start = 1'b1; out_ready = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            drain_start = (c == rs_cyc);
            if (c == rs_cyc) begin
                drain_base = 4'd0; drain_count = 5'd1;
            end
            wr_en = (c == wr_cyc); wr_addr = wa; wr_data = wd;
            if (out_valid && nwords == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
                chk($sformatf("stall_addr%0d", stalled), 32'(out_addr), 32'(base + 4'(stall_at)));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && nwords < 32) begin
                got_data[nwords] = out_data;
                got_addr[nwords] = out_addr;
                got_last[nwords] = out_last;
                nwords++;
            end
            if (drain_done)
                done_cyc = c;
            tick();
        end
        wr_en = 1'b0; drain_start = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(drain_done), 0);
        chk("rst_unwr", 32'(rd_unwritten), 0);
        chk("rst_occ", 32'(occupancy), 0);
        rst = 1'b0;
        tick();

        // basic fill and drain
        wr(4'd0, 32'd10); wr(4'd1, 32'd20); wr(4'd2, 32'd30); wr(4'd3, 32'd40);
        chk("t1_occ_full", 32'(occupancy), OCC ? 32'd4 : 32'd0);
        run_drain(4'd0, 5'd4, -1, 0, -1, 4'd0, 32'd0, -1);
        chk("t1_nwords", nwords, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), 32'(got_addr[i]), i);
            chk($sformatf("t1_data%0d", i), got_data[i], 32'((i + 1) * 10));
            chk($sformatf("t1_last%0d", i), 32'(got_last[i]), (i == 3) ? 1 : 0);
        end
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_unwr", 32'(rd_unwritten), 0);
        chk("t1_occ_empty", 32'(occupancy), 0);

        // wrap 14 -> 15 -> 0
        wr(4'd14, 32'hA); wr(4'd15, 32'hB); wr(4'd0, 32'hC);
        run_drain(4'd14, 5'd3, -1, 0, -1, 4'd0, 32'd0, -1);
        chk("t2_nwords", nwords, 3);
        chk("t2_addr0", 32'(got_addr[0]), 14); chk("t2_data0", got_data[0], 32'hA);
        chk("t2_addr1", 32'(got_addr[1]), 15); chk("t2_data1", got_data[1], 32'hB);
        chk("t2_addr2", 32'(got_addr[2]), 0);  chk("t2_data2", got_data[2], 32'hC);
        chk("t2_done_cyc", done_cyc, 5);

        // back-pressure: 3 stall cycles on the second word
        for (int i = 0; i < 4; i++) wr(4'(8 + i), 32'h100 + 32'(i));
        run_drain(4'd8, 5'd4, 1, 3, -1, 4'd0, 32'd0, -1);
        chk("t3_nwords", nwords, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_addr%0d", i), 32'(got_addr[i]), 8 + i);
            chk($sformatf("t3_data%0d", i), got_data[i], 32'h100 + 32'(i));
        end
        chk("t3_done_cyc", done_cyc, 9);
        chk("t3_occ", 32'(occupancy), 0);

        // entry 5 unwritten, entry 6 written in its own load cycle
        run_drain(4'd5, 5'd2, -1, 0, 2, 4'd6, 32'h55, -1);
        chk("t4_nwords", nwords, 2);
        chk("t4_data0", got_data[0], 0);
        chk("t4_addr1", 32'(got_addr[1]), 6);
        chk("t4_data1", got_data[1], 32'h55);
        chk("t4_unwr", 32'(rd_unwritten), 1);
        chk("t4_occ", 32'(occupancy), 0);

        // zero count is ignored
        drain_base = 4'd0; drain_count = 5'd0; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        chk("t5_zero_busy", 32'(busy), 0);
        tick();
        chk("t5_zero_valid", 32'(out_valid), 0);

        // count 20 clamps to 16; a second request while busy is ignored
        run_drain(4'd3, 5'd20, -1, 0, -1, 4'd0, 32'd0, 3);
        chk("t5_nwords", nwords, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t5_addr%0d", i), 32'(got_addr[i]), (3 + i) % 16);
        chk("t5_last15", 32'(got_last[15]), 1);
        chk("t5_last14", 32'(got_last[14]), 0);
        chk("t5_done_cyc", done_cyc, 18);
        chk("t5_busy_after", 32'(busy), 0);
        tick();
        chk("t5_no_requeue", 32'(busy), 0);

        // asynchronous reset in SEND
        wr(4'd2, 32'h77);
        drain_base = 4'd2; drain_count = 5'd3; drain_start = 1'b1; out_ready = 1'b0;
        tick();
        drain_start = 1'b0;
        tick();
        chk("t6_pre_valid", 32'(out_valid), 1);
        chk("t6_pre_data", out_data, 32'h77);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_occ", 32'(occupancy), 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        run_drain(4'd2, 5'd1, -1, 0, -1, 4'd0, 32'd0, -1);
        chk("t6_nwords", nwords, 1);
        chk("t6_data", got_data[0], 0);
        chk("t6_unwr", 32'(rd_unwritten), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
